alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result bit width (legal ≥ 4).
REQ-002 Parameter MUL_EN, default 1, enables the iterative multiply mode; 0 means mul is ignored and treated as 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is asynchronous and active-low.
REQ-005 in_valid  input  1  request presented.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 x, y  input  WIDTH  operands.
REQ-008 zx, nx, zy, ny, f, no  input  1 each  Hack ALU control bits.
REQ-009 mul  input  1  1 selects multiply mode; f is ignored in that mode.
REQ-010 out_valid  output  1  result held and valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  WIDTH  registered result.
REQ-013 zr, ng  output  1 each  out==0, out[WIDTH-1].
REQ-014 busy  output  1  high while a multiply is iterating.

Function
REQ-015 A request is accepted on a rising edge where in_valid && in_ready; x, y and all control bits are captured at that edge and later input changes have no effect on it.
REQ-016 Preprocessing: xa = zx ? 0 : x, then xa = nx ? ~xa : xa; the same rule applies to y with zy/ny.
REQ-017 Normal mode (mul=0): r = f ? (xa+yb) mod 2^WIDTH : xa&yb, then out = no ? ~r : r, giving bit-exact Hack ALU semantics at any WIDTH.
REQ-018 Multiply mode (mul=1, MUL_EN=1): r = (xa*yb) mod 2^WIDTH as unsigned shift-add, one multiplier bit per cycle, then out = no ? ~r : r.
REQ-019 FSM states are IDLE, MUL, DONE.
- IDLE: accept normal → DONE; accept mul → MUL.
- MUL: WIDTH cycles → DONE.
- DONE: out_ready → IDLE, or directly back to DONE/MUL if a new request is accepted the same edge.
REQ-020 Latency: normal-mode out_valid rises 1 cycle after the accept edge; multiply-mode out_valid rises WIDTH+1 cycles after the accept edge.
REQ-021 in_ready = (state==IDLE) || (state==DONE && out_ready); this allows back-to-back normal ops at 1 result per cycle.
REQ-022 out_valid = (state==DONE); busy = (state==MUL).
REQ-023 While out_valid && !out_ready, out/zr/ng shall hold stable and in_ready shall be 0.
REQ-024 zr and ng are derived combinationally from the out register only, never from unregistered paths.
REQ-025 in_valid asserted while in_ready=0 is ignored; no request is queued.
REQ-026 The out register updates only when a result completes (normal accept edge or final MUL cycle); it is otherwise held, including in IDLE.

Reset
REQ-027 rst_n low immediately forces state=IDLE, out=0, out_valid=0, busy=0 and clears the multiply accumulator/counter; zr=1, ng=0, in_ready=1 follow from these values.
REQ-028 Reset asserted mid-multiply or while DONE aborts the operation; no result is produced after rst_n deasserts.
REQ-029 After rst_n rises, the first accept may occur on the first subsequent rising edge.

Verification
REQ-030 WIDTH=16, x=17, y=3, out_ready=1, all 18 Hack control codes back-to-back:
- results: 0, 1, -1, 17, 3, !17, !3, -17, -3, 18, 4, 16, 2, 20, 14, -14, 1, 19;
- one result per cycle;
- zr/ng correct for each result.
REQ-031 x=0, y=16'hFFFF, code x+y (000010) → out=FFFF, ng=1, zr=0; code 0 (101010) → out=0, zr=1, ng=0.
REQ-032 mul=1, x=17, y=3, code 000000 → busy for 16 cycles, out=51 at cycle 17, in_ready=0 throughout; x=300, y=300 → out=0x5F90 (truncated 90000).
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after a result → out, zr, ng stable, in_ready=0, new in_valid ignored; then raise out_ready with a pending request → accepted on that same edge.
REQ-034 Pull rst_n low asynchronously at cycle 8 of a multiply → outputs go to reset values immediately, no out_valid after release; the next normal op completes in 1 cycle.
REQ-035 Rerun REQ-030 and REQ-032 with WIDTH=8 and WIDTH=32 against a reference model → all results match.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - Pipelined Hack ALU with registered result and iterative shift-add multiply
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             no_q, no_d;

    logic             accept;
    logic             mul_sel;
    logic [WIDTH-1:0] xa, yb, r_norm, acc_sum;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_sel  = MUL_EN && mul;

    always_comb begin
        xa = zx ? '0 : x;
        if (nx) xa = ~xa;
        yb = zy ? '0 : y;
        if (ny) yb = ~yb;
        r_norm = f ? (xa + yb) : (xa & yb);
    end

    // One multiplier bit per cycle: multiplicand shifts left, multiplier shifts right.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        no_d     = no_q;

        case (state_q)
            S_IDLE: ;
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    out_d   = no_q ? ~acc_sum : acc_sum;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Accepting only happens in IDLE or a draining DONE, so it never collides with MUL.
        if (accept) begin
            if (mul_sel) begin
                state_d  = S_MUL;
                acc_d    = '0;
                mcand_d  = xa;
                mplier_d = yb;
                cnt_d    = '0;
                no_d     = no;
            end else begin
                state_d = S_DONE;
                out_d   = no ? ~r_norm : r_norm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            out_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            no_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            no_q     <= no_d;
        end
    end

    assign out       = out_q;
    assign zr        = (out_q == '0);
    assign ng        = out_q[WIDTH-1];
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - Directed vector bench for alu_pipe at WIDTH 16 with 8/32-bit companions
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] x32, y32;
    logic        zx, nx, zy, ny, f, no, mul;

    logic        in_ready16, out_valid16, zr16, ng16, busy16;
    logic [15:0] out16;
    logic        in_ready8, out_valid8, zr8, ng8, busy8;
    logic [7:0]  out8;
    logic        in_ready32, out_valid32, zr32, ng32, busy32;
    logic [31:0] out32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .x(x32[15:0]), .y(y32[15:0]), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .mul(mul), .out_valid(out_valid16), .out_ready(out_ready), .out(out16),
        .zr(zr16), .ng(ng16), .busy(busy16));

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .x(x32[7:0]), .y(y32[7:0]), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .mul(mul), .out_valid(out_valid8), .out_ready(out_ready), .out(out8),
        .zr(zr8), .ng(ng8), .busy(busy8));

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .x(x32), .y(y32), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .mul(mul), .out_valid(out_valid32), .out_ready(out_ready), .out(out32),
        .zr(zr32), .ng(ng32), .busy(busy32));

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  code;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int w, input logic [31:0] xi, input logic [31:0] yi,
                                            input logic [5:0] c, input logic m);
        logic [63:0] one, mask, xa, yb, r;
        one  = 64'd1;
        mask = (one << w) - 64'd1;
        xa   = c[5] ? 64'd0 : {32'd0, xi} & mask;
        xa   = (c[4] ? ~xa : xa) & mask;
        yb   = c[3] ? 64'd0 : {32'd0, yi} & mask;
        yb   = (c[2] ? ~yb : yb) & mask;
        r    = m ? xa * yb : (c[1] ? xa + yb : xa & yb);
        r    = (c[0] ? ~r : r) & mask;
        return r[31:0];
    endfunction

    task automatic set_op(input logic [31:0] xv, input logic [31:0] yv, input logic [5:0] c, input logic m);
        x32 = xv; y32 = yv;
        {zx, nx, zy, ny, f, no} = c;
        mul = m;
    endtask

    task automatic add_vec(input int i, input logic [15:0] xv, input logic [15:0] yv,
                           input logic [5:0] c, input logic [15:0] e);
        tbl[i].x = xv; tbl[i].y = yv; tbl[i].code = c; tbl[i].exp = e;
    endtask

    task automatic run_mul(input logic [31:0] xv, input logic [31:0] yv, input logic [15:0] exp16);
        int bad, c8, c16, c32;
        logic [31:0] o8, o16, o32;
        bad = 0; c8 = 0; c16 = 0; c32 = 0; o8 = 0; o16 = 0; o32 = 0;
        @(negedge clk);
        set_op(xv, yv, 6'b000000, 1'b1);
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                in_valid = 1'b0;
                set_op(32'h3E7, 32'h5, 6'b000010, 1'b0);
            end
            if (cyc <= 16 && (busy16 !== 1'b1 || in_ready16 !== 1'b0 || out_valid16 !== 1'b0)) bad++;
            if (out_valid16 && c16 == 0) begin c16 = cyc; o16 = {16'd0, out16}; end
            if (out_valid8  && c8  == 0) begin c8  = cyc; o8  = {24'd0, out8};  end
            if (out_valid32 && c32 == 0) begin c32 = cyc; o32 = out32;          end
        end
        chk("mul16 busy/in_ready/out_valid violations", bad, 0);
        chk("mul16 latency", c16, 17);
        chk("mul16 out", o16, {16'd0, exp16});
        chk("mul8 latency", c8, 9);
        chk("mul8 out", o8, ref_alu(8, xv, yv, 6'b000000, 1'b1));
        chk("mul32 latency", c32, 33);
        chk("mul32 out", o32, ref_alu(32, xv, yv, 6'b000000, 1'b1));
    endtask

    initial begin
        int hold_bad, ov_cnt;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(32'd0, 32'd0, 6'b000000, 1'b0);

        add_vec(0,  16'd17, 16'd3, 6'b101010, 16'd0);
        add_vec(1,  16'd17, 16'd3, 6'b111111, 16'd1);
        add_vec(2,  16'd17, 16'd3, 6'b111010, 16'hFFFF);
        add_vec(3,  16'd17, 16'd3, 6'b001100, 16'd17);
        add_vec(4,  16'd17, 16'd3, 6'b110000, 16'd3);
        add_vec(5,  16'd17, 16'd3, 6'b001101, 16'hFFEE);
        add_vec(6,  16'd17, 16'd3, 6'b110001, 16'hFFFC);
        add_vec(7,  16'd17, 16'd3, 6'b001111, 16'hFFEF);
        add_vec(8,  16'd17, 16'd3, 6'b110011, 16'hFFFD);
        add_vec(9,  16'd17, 16'd3, 6'b011111, 16'd18);
        add_vec(10, 16'd17, 16'd3, 6'b110111, 16'd4);
        add_vec(11, 16'd17, 16'd3, 6'b001110, 16'd16);
        add_vec(12, 16'd17, 16'd3, 6'b110010, 16'd2);
        add_vec(13, 16'd17, 16'd3, 6'b000010, 16'd20);
        add_vec(14, 16'd17, 16'd3, 6'b010011, 16'd14);
        add_vec(15, 16'd17, 16'd3, 6'b000111, 16'hFFF2);
        add_vec(16, 16'd17, 16'd3, 6'b000000, 16'd1);
        add_vec(17, 16'd17, 16'd3, 6'b010101, 16'd19);
        add_vec(18, 16'd0,  16'hFFFF, 6'b000010, 16'hFFFF);
        add_vec(19, 16'd0,  16'hFFFF, 6'b101010, 16'd0);

        #12;
        chk("reset out", {16'd0, out16}, 32'd0);
        chk("reset zr", zr16, 1'b1);
        chk("reset ng", ng16, 1'b0);
        chk("reset in_ready", in_ready16, 1'b1);
        chk("reset out_valid", out_valid16, 1'b0);
        chk("reset busy", busy16, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back normal ops, one result expected per cycle.
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("tbl%0d out_valid", i-1), out_valid16, 1'b1);
                chk($sformatf("tbl%0d in_ready", i-1), in_ready16, 1'b1);
                chk($sformatf("tbl%0d out", i-1), {16'd0, out16}, {16'd0, tbl[i-1].exp});
                chk($sformatf("tbl%0d zr", i-1), zr16, tbl[i-1].exp == 16'd0);
                chk($sformatf("tbl%0d ng", i-1), ng16, tbl[i-1].exp[15]);
                chk($sformatf("tbl%0d w8 out", i-1), {24'd0, out8},
                    ref_alu(8, {16'd0, tbl[i-1].x}, {16'd0, tbl[i-1].y}, tbl[i-1].code, 1'b0));
                chk($sformatf("tbl%0d w32 out", i-1), out32,
                    ref_alu(32, {16'd0, tbl[i-1].x}, {16'd0, tbl[i-1].y}, tbl[i-1].code, 1'b0));
            end
            if (i < 20) begin
                set_op({16'd0, tbl[i].x}, {16'd0, tbl[i].y}, tbl[i].code, 1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        run_mul(32'd17, 32'd3, 16'd51);
        run_mul(32'd300, 32'd300, 16'h5F90);

        // Backpressure: result held while a competing request waits.
        @(negedge clk);
        set_op(32'd17, 32'd3, 6'b000010, 1'b0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        set_op(32'd17, 32'd3, 6'b000000, 1'b0);
        hold_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid16 !== 1'b1 || out16 !== 16'd20 || zr16 !== 1'b0 ||
                ng16 !== 1'b0 || in_ready16 !== 1'b0) hold_bad++;
            @(negedge clk);
        end
        chk("backpressure hold violations", hold_bad, 0);
        chk("backpressure held out", {16'd0, out16}, 32'd20);
        out_ready = 1'b1;
        #1;
        chk("backpressure release in_ready", in_ready16, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("backpressure new out_valid", out_valid16, 1'b1);
        chk("backpressure new out", {16'd0, out16}, 32'd1);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        set_op(32'd17, 32'd3, 6'b000000, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c < 8; c++) @(negedge clk);
        chk("pre-abort busy", busy16, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", busy16, 1'b0);
        chk("abort out", {16'd0, out16}, 32'd0);
        chk("abort out_valid", out_valid16, 1'b0);
        chk("abort in_ready", in_ready16, 1'b1);
        chk("abort zr", zr16, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid16 || out_valid8 || out_valid32 || busy16) ov_cnt++;
        end
        chk("no result after abort", ov_cnt, 0);
        set_op(32'd17, 32'd3, 6'b000010, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post-reset op out_valid", out_valid16, 1'b1);
        chk("post-reset op out", {16'd0, out16}, 32'd20);
        @(negedge clk);
        chk("post-reset op drained", out_valid16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
